// File: rtl/tnn_stream_classifier.sv
`default_nettype none
// tnn_stream_classifier: streaming ternary-weight neural classifier. It takes one feature
// per beat, keeps N_HID signed accumulators, thresholds them and then takes a popcount vote.
module tnn_stream_classifier #(
  parameter int FEAT_W = 2,
  parameter int N_FEAT = 4,
  parameter int N_HID  = 4,
  parameter int ACC_W  = FEAT_W + $clog2(N_FEAT) + 2,
  parameter logic [N_HID*N_FEAT*2-1:0] W_TERN = '0,
  parameter logic [N_HID*ACC_W-1:0]    THR    = '0,
  parameter int OUT_THR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_class,
  output logic [N_HID-1:0]  out_hid,
  output logic              err
);

  localparam int CNT_W = $clog2(N_FEAT);
  localparam int POP_W = $clog2(N_HID + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_EVAL = 2'd1,
    ST_POP  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc     [N_HID];
  logic signed [ACC_W-1:0]  acc_nxt [N_HID];
  logic signed [ACC_W-1:0]  feat_ext;
  logic [N_HID-1:0]         hid_nxt;
  logic [POP_W-1:0]         pop;
  logic                     class_nxt;
  logic                     take, is_final, frame_end, frame_err, out_take;

  assign take      = in_valid & in_ready & (state == ST_ACC);
  assign is_final  = (cnt == LAST_IDX);
  assign frame_end = take & in_last & is_final;
  // A frame is bad when in_last is set on any beat other than the last one, or when it is missing on the last beat.
  assign frame_err = take & (in_last ^ is_final);
  assign out_take  = (state == ST_OUT) & out_ready;
  assign feat_ext  = {{(ACC_W-FEAT_W){1'b0}}, in_data};

  always_comb begin
    for (int h = 0; h < N_HID; h++) begin
      acc_nxt[h] = acc[h];
      case (W_TERN[(h*N_FEAT + int'(cnt))*2 +: 2])
        2'b01:   acc_nxt[h] = acc[h] + feat_ext;
        2'b11:   acc_nxt[h] = acc[h] - feat_ext;
        default: acc_nxt[h] = acc[h];
      endcase
    end
  end

  always_comb begin
    hid_nxt = '0;
    for (int h = 0; h < N_HID; h++)
      hid_nxt[h] = (acc[h] >= $signed(THR[h*ACC_W +: ACC_W]));
  end

  always_comb begin
    pop = '0;
    for (int h = 0; h < N_HID; h++)
      pop = pop + POP_W'(out_hid[h]);
    class_nxt = (int'(pop) >= OUT_THR);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (frame_end) state_nxt = ST_EVAL;
      ST_EVAL: state_nxt = ST_POP;
      ST_POP:  state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // The handshake flags are registered copies of the next state, so each one changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_class <= 1'b0;
      out_hid   <= '0;
      err       <= 1'b0;
      for (int h = 0; h < N_HID; h++) acc[h] <= '0;
    end else begin
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_OUT);
      err       <= frame_err;
      if (frame_err || out_take) begin
        cnt <= '0;
        for (int h = 0; h < N_HID; h++) acc[h] <= '0;
      end else if (take) begin
        cnt <= frame_end ? '0 : cnt + CNT_W'(1);
        for (int h = 0; h < N_HID; h++) acc[h] <= acc_nxt[h];
      end
      if (state == ST_EVAL) out_hid   <= hid_nxt;
      if (state == ST_POP)  out_class <= class_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tnn_stream_classifier.sv
`default_nettype none
// tb_tnn_stream_classifier: five differently parameterised classifiers run in lockstep from one stream;
// their results are compared with a table and with an arithmetic frame model.
module tb_tnn_stream_classifier;

  localparam logic [31:0] W0 = '0;
  localparam logic [23:0] T0 = '0;
  localparam logic [7:0]  W1 = 8'h55;
  localparam logic [5:0]  T1 = 6'd7;
  localparam logic [15:0] W2 = 16'h00DD;
  localparam logic [11:0] T2 = 12'h040;
  localparam logic [23:0] W4 = 24'h9D4F37;
  localparam logic [17:0] T4 = {6'd3, 6'h3F, 6'd0};

  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, out_ready;
  logic [1:0] in_data;
  logic [4:0] ir, ov, oc, er;
  logic [3:0] oh0;
  logic [0:0] oh1;
  logic [1:0] oh2, oh3;
  logic [2:0] oh4;

  int total = 0;
  int bad = 0;
  int feat [4];
  bit rand_gaps = 0;

  typedef struct {
    int         f [4];
    logic [3:0] h0;
    logic       c0;
    logic       h1;
    logic       c1;
    logic [1:0] h2;
    logic       c2;
    logic       c3;
  } vec_t;
  vec_t tab [5];

  always #5 clk = ~clk;

  tnn_stream_classifier u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
    .out_class(oc[0]), .out_hid(oh0), .err(er[0]));
  tnn_stream_classifier #(.N_HID(1), .W_TERN(W1), .THR(T1)) u1 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_class(oc[1]), .out_hid(oh1), .err(er[1]));
  tnn_stream_classifier #(.N_HID(2), .W_TERN(W2), .THR(T2), .OUT_THR(2)) u2 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_class(oc[2]), .out_hid(oh2), .err(er[2]));
  tnn_stream_classifier #(.N_HID(2), .W_TERN(W2), .THR(T2), .OUT_THR(1)) u3 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data), .in_last(in_last), .out_valid(ov[3]),
    .out_ready(out_ready), .out_class(oc[3]), .out_hid(oh3), .err(er[3]));
  tnn_stream_classifier #(.N_HID(3), .W_TERN(W4), .THR(T4), .OUT_THR(2)) u4 (.clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[4]), .in_data(in_data), .in_last(in_last), .out_valid(ov[4]),
    .out_ready(out_ready), .out_class(oc[4]), .out_hid(oh4), .err(er[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame model: plain integer dot products, a signed threshold and a vote. Result is {class, hid[3:0]}.
  function automatic logic [4:0] model(input logic [63:0] w, input logic [63:0] thr, input int nh, input int othr);
    logic [3:0] hid = '0;
    int pop = 0;
    for (int h = 0; h < nh; h++) begin
      int s = 0;
      int t;
      for (int f = 0; f < 4; f++) begin
        logic [1:0] code = w[(h*4+f)*2 +: 2];
        if (code == 2'b01) s += feat[f];
        else if (code == 2'b11) s -= feat[f];
      end
      t = int'(thr[h*6 +: 6]);
      if (t >= 32) t -= 64;
      if (s >= t) begin
        hid[h] = 1'b1;
        pop++;
      end
    end
    return {(pop >= othr), hid};
  endfunction

  task automatic compare_all(input string tag);
    logic [4:0] m;
    m = model(64'(W0), 64'(T0), 4, 1);
    chk({tag, "_hid0"}, 32'(oh0), 32'(m[3:0]));  chk({tag, "_cls0"}, 32'(oc[0]), 32'(m[4]));
    m = model(64'(W1), 64'(T1), 1, 1);
    chk({tag, "_hid1"}, 32'(oh1), 32'(m[0]));    chk({tag, "_cls1"}, 32'(oc[1]), 32'(m[4]));
    m = model(64'(W2), 64'(T2), 2, 2);
    chk({tag, "_hid2"}, 32'(oh2), 32'(m[1:0]));  chk({tag, "_cls2"}, 32'(oc[2]), 32'(m[4]));
    m = model(64'(W2), 64'(T2), 2, 1);
    chk({tag, "_hid3"}, 32'(oh3), 32'(m[1:0]));  chk({tag, "_cls3"}, 32'(oc[3]), 32'(m[4]));
    m = model(64'(W4), 64'(T4), 3, 2);
    chk({tag, "_hid4"}, 32'(oh4), 32'(m[2:0]));  chk({tag, "_cls4"}, 32'(oc[4]), 32'(m[4]));
  endtask

  task automatic beat(input int d, input logic last);
    int n = 0;
    @(negedge clk);
    if (rand_gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 2'(d);
    in_last  = last;
    while (!ir[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ir[0]) chk("beat_timeout", 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 4; i++) beat(feat[i], i == 3);
  endtask

  // Entered just after the last-beat handshake edge. out_valid must appear on the third edge after it.
  task automatic finish_frame(input int hold, input int ti, input bit use_tab);
    @(negedge clk);
    if (hold > 0) out_ready = 1'b0;
    chk("in_ready_drop", 32'(ir), 32'h0);
    chk("ov_t1", 32'(ov), 32'h0);
    @(negedge clk);
    chk("ov_t2", 32'(ov), 32'h0);
    @(negedge clk);
    chk("ov_t3", 32'(ov), 32'h1f);
    compare_all("res");
    if (use_tab) begin
      chk("tab_hid0", 32'(oh0), 32'(tab[ti].h0)); chk("tab_cls0", 32'(oc[0]), 32'(tab[ti].c0));
      chk("tab_hid1", 32'(oh1), 32'(tab[ti].h1)); chk("tab_cls1", 32'(oc[1]), 32'(tab[ti].c1));
      chk("tab_hid2", 32'(oh2), 32'(tab[ti].h2)); chk("tab_cls2", 32'(oc[2]), 32'(tab[ti].c2));
      chk("tab_hid3", 32'(oh3), 32'(tab[ti].h2)); chk("tab_cls3", 32'(oc[3]), 32'(tab[ti].c3));
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 2'd3;
      in_last  = 1'b1;
      @(negedge clk);
      chk("hold_ov", 32'(ov), 32'h1f);
      chk("hold_ir", 32'(ir), 32'h0);
      compare_all("hold");
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("ov_clear", 32'(ov), 32'h0);
    chk("ir_back", 32'(ir), 32'h1f);
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                         input logic [3:0] h0, input logic c0, input logic h1, input logic c1,
                         input logic [1:0] h2, input logic c2, input logic c3);
    tab[i].f[0] = a; tab[i].f[1] = b; tab[i].f[2] = c; tab[i].f[3] = d;
    tab[i].h0 = h0; tab[i].c0 = c0; tab[i].h1 = h1; tab[i].c1 = c1;
    tab[i].h2 = h2; tab[i].c2 = c2; tab[i].c3 = c3;
  endtask

  task automatic load_feat(input int i);
    for (int f = 0; f < 4; f++) feat[f] = tab[i].f[f];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 3, 2, 1, 0, 4'hf, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    set_vec(1, 3, 3, 1, 0, 4'hf, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    set_vec(2, 0, 3, 0, 3, 4'hf, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    set_vec(3, 3, 0, 3, 0, 4'hf, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
    set_vec(4, 1, 1, 1, 1, 4'hf, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);

    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_ir", 32'(ir), 32'h0);  chk("rst_ov", 32'(ov), 32'h0);
    chk("rst_oc", 32'(oc), 32'h0);  chk("rst_err", 32'(er), 32'h0);
    chk("rst_hid0", 32'(oh0), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ir_before_edge", 32'(ir), 32'h0);
    @(negedge clk);
    chk("ir_after_edge", 32'(ir), 32'h1f);

    for (int i = 0; i < 5; i++) begin
      load_feat(i);
      send_frame();
      finish_frame((i == 1) ? 5 : 0, i, 1'b1);
    end

    // in_last arrives early, on beat 2
    beat(1, 1'b0);
    beat(1, 1'b1);
    @(negedge clk);
    chk("err1_pulse", 32'(er), 32'h1f); chk("err1_ir", 32'(ir), 32'h1f); chk("err1_ov", 32'(ov), 32'h0);
    @(negedge clk);
    chk("err1_end", 32'(er), 32'h0);
    repeat (3) @(negedge clk);
    chk("err1_no_ov", 32'(ov), 32'h0);
    load_feat(4);
    send_frame();
    finish_frame(0, 4, 1'b1);

    // in_last is missing on beat 4
    for (int i = 0; i < 4; i++) beat(2, 1'b0);
    @(negedge clk);
    chk("err2_pulse", 32'(er), 32'h1f); chk("err2_ir", 32'(ir), 32'h1f);
    @(negedge clk);
    chk("err2_end", 32'(er), 32'h0);
    load_feat(3);
    send_frame();
    finish_frame(0, 3, 1'b1);

    // reset is asserted after two beats of a frame
    beat(3, 1'b0);
    beat(2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", 32'(ir), 32'h0);  chk("mid_rst_ov", 32'(ov), 32'h0);
    chk("mid_rst_oc", 32'(oc), 32'h0);  chk("mid_rst_hid0", 32'(oh0), 32'h0);
    chk("mid_rst_err", 32'(er), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ir_up", 32'(ir), 32'h1f);
    load_feat(0);
    send_frame();
    finish_frame(0, 0, 1'b1);

    rand_gaps = 1;
    for (int n = 0; n < 30; n++) begin
      for (int f = 0; f < 4; f++) feat[f] = int'($urandom_range(0, 3));
      send_frame();
      finish_frame(int'($urandom_range(0, 2)), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tnn_stream_classifier.md
Name: tnn_stream_classifier

Overview:
- Parametrised, sequential successor to the team's fixed 4-feature, 2-bit combinational classifier cores.
- Accepts one feature vector as a valid/ready stream, one feature per beat.
- Accumulates ternary-weighted sums for N_HID hidden neurons and thresholds each one.
- Emits a 1-bit class from a popcount vote over the hidden bits. Sits between the feature-quantiser stream and the result collector.

Parameters:
- FEAT_W, 2: unsigned width of each feature.
- N_FEAT, 4: features per frame (>=2).
- N_HID, 4: number of hidden ternary neurons (>=1).
- ACC_W, FEAT_W+$clog2(N_FEAT)+2: signed accumulator width.
- W_TERN, 0: packed N_HID*N_FEAT*2 bits.
  - Weight for hidden h, feature f is W_TERN[(h*N_FEAT+f)*2 +: 2].
  - Encoding: 01 = +1, 11 = -1, 00 or 10 = 0.
- THR, 0: packed N_HID*ACC_W signed thresholds. THR[h*ACC_W +: ACC_W].
- OUT_THR, 1: class = 1 when popcount(hidden) >= OUT_THR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  FEAT_W  unsigned feature.
- in_last  in  1  marks the final feature of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  1  classification bit.
- out_hid  out  N_HID  hidden-neuron bits for the frame (debug/verification).
- err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = ACC.
  - Feature counter = 0, all accumulators = 0.
  - in_ready = 0, out_valid = 0, out_class = 0, out_hid = 0, err = 0.
  - in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- States: ACC -> EVAL -> POP -> OUT -> ACC.
- ACC:
  - in_ready = 1.
  - On a handshake (in_valid & in_ready) at feature index f, each acc[h] += w(h,f) * zero-extended in_data.
  - Counter increments on each handshake.
- Frame completion:
  - A handshake with f == N_FEAT-1 and in_last = 1 is the last beat (cycle t).
  - in_ready drops at t+1.
  - State is EVAL during t+1, POP during t+2, OUT from t+3.
- EVAL: hid[h] = (acc[h] >= THR[h]), signed compare. Result is registered into out_hid.
- POP: out_class = (popcount(out_hid) >= OUT_THR). Result is registered.
- OUT:
  - out_valid = 1 from t+3. out_class and out_hid are held stable until the handshake.
  - On the out_valid & out_ready edge: out_valid -> 0, accumulators and counter cleared, state -> ACC, in_ready -> 1 on that same edge.
  - There is no bypass: the first beat of the next frame is accepted at the earliest on the following cycle.
- Fixed latency: last-beat handshake to out_valid is exactly 3 cycles, independent of N_HID and N_FEAT.
- Framing errors:
  - Either error case: frame discarded, accumulators and counter cleared, err = 1 for exactly the next cycle, state stays ACC, in_ready stays 1.
  - Case 1: in_last = 1 with f < N_FEAT-1.
  - Case 2: in_last = 0 with f == N_FEAT-1.
- Beats presented while in_ready = 0 are ignored and not consumed. The upstream must hold its data.
- Arithmetic:
  - Features are unsigned. Accumulation is signed two's-complement in ACC_W bits.
  - The default ACC_W cannot overflow for full-range features with all weights +1 or all weights -1.
- Reset asserted mid-frame or mid-OUT aborts everything. No partial result and no err pulse are produced.
- Default parameters:
  - All weights 0 and all thresholds 0, so every hidden bit is 1 and out_class is always 1.
  - This is the degenerate constant classifier used as the regression baseline.

Test Plan:
- Default params; beats 3,2,1,0 with in_last on the 4th beat; out_ready = 1 -> out_valid exactly 3 cycles after the last handshake, out_hid = 4'b1111, out_class = 1, in_ready back to 1 one cycle later.
- N_HID=1, all weights +1, THR=7 -> frame 3,2,1,0 (sum 6) gives out_hid = 0, out_class = 0; frame 3,3,1,0 (sum 7) gives out_class = 1.
- N_HID=2, neuron0 weights {+1,-1,+1,-1}, THR0 = 0, neuron1 weights all 0, THR1 = 1, OUT_THR = 2 -> frame 0,3,0,3 (acc0 = -6) gives out_hid = 2'b00, class 0; frame 3,0,3,0 (acc0 = +6) gives out_hid = 2'b01, class 0 (popcount 1 < 2); rerun with OUT_THR = 1 -> class 1.
- Back-pressure: after a result, hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_valid, out_class, out_hid stable, in_ready = 0, no beat consumed; on release the next frame is processed correctly.
- Framing errors:
  - in_last on beat 2 -> err pulses 1 cycle, no out_valid; following well-formed frame 1,1,1,1 gives the correct result.
  - Missing in_last on beat 4 -> same err behaviour.
- Pull rst_n low after 2 accepted beats -> all outputs 0 immediately; after release, a fresh 4-beat frame gives the same result as the first scenario.
